// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - prescaled LED pattern sequencer (rotate, ping-pong, flash, hold)
// Pattern and bounce direction advance only on prescaler ticks; bank routing is combinational.
module led_sequencer #(
   parameter int unsigned N_LEDS = 4,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned LIMIT0 = 2,
   parameter int unsigned LIMIT1 = 4,
   parameter int unsigned LIMIT2 = 8,
   parameter int unsigned LIMIT3 = 16
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [3:0]        i_sw,
   input  logic [1:0]        i_mode,
   input  logic [1:0]        i_color,
   output logic [N_LEDS-1:0] o_led,
   output logic [N_LEDS-1:0] o_led_g,
   output logic [N_LEDS-1:0] o_led_b,
   output logic              o_valid
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   typedef enum logic [1:0] {
      MODE_ROTATE   = 2'b00,
      MODE_PINGPONG = 2'b01,
      MODE_FLASH    = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_t;

   localparam logic [N_LEDS-1:0] PAT_INIT = N_LEDS'(1);
   localparam logic [N_LEDS-1:0] PAT_ONES = {N_LEDS{1'b1}};

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  lim;
   logic [N_LEDS-1:0] pat;
   logic [N_LEDS-1:0] pat_nxt;
   dir_t              bdir;
   dir_t              bdir_nxt;
   mode_t             mode;
   logic              enable;
   logic              period_done;
   logic              one_hot;

   assign enable = i_sw[0];
   assign mode   = mode_t'(i_mode);

   always_comb begin
      lim = CNT_W'(LIMIT0);
      case (i_sw[2:1])
         2'b00:   lim = CNT_W'(LIMIT0);
         2'b01:   lim = CNT_W'(LIMIT1);
         2'b10:   lim = CNT_W'(LIMIT2);
         default: lim = CNT_W'(LIMIT3);
      endcase
   end

   // >= rather than == so shrinking the limit below cnt ends the period at once
   assign period_done = (cnt >= (lim - CNT_W'(1)));

   assign one_hot = (pat != '0) && ((pat & (pat - N_LEDS'(1))) == '0);

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         cnt     <= '0;
         o_valid <= 1'b0;
         pat     <= PAT_INIT;
         bdir    <= DIR_UP;
      end else if (enable) begin
         if (period_done) begin
            cnt     <= '0;
            o_valid <= 1'b1;
            pat     <= pat_nxt;
            bdir    <= bdir_nxt;
         end else begin
            cnt     <= cnt + CNT_W'(1);
            o_valid <= 1'b0;
         end
      end else begin
         o_valid <= 1'b0;
      end
   end

   always_comb begin
      pat_nxt  = pat;
      bdir_nxt = bdir;
      case (mode)
         MODE_ROTATE: begin
            if (!one_hot) begin
               pat_nxt  = PAT_INIT;
               bdir_nxt = DIR_UP;
            end else if (i_sw[3]) begin
               pat_nxt = {pat[0], pat[N_LEDS-1:1]};
            end else begin
               pat_nxt = {pat[N_LEDS-2:0], pat[N_LEDS-1]};
            end
         end
         MODE_PINGPONG: begin
            // reversal and the step happen on the same tick, so the ends never dwell
            if (!one_hot) begin
               pat_nxt  = PAT_INIT;
               bdir_nxt = DIR_UP;
            end else if (bdir == DIR_UP) begin
               if (pat[N_LEDS-1]) begin
                  bdir_nxt = DIR_DOWN;
                  pat_nxt  = pat >> 1;
               end else begin
                  pat_nxt = pat << 1;
               end
            end else begin
               if (pat[0]) begin
                  bdir_nxt = DIR_UP;
                  pat_nxt  = pat << 1;
               end else begin
                  pat_nxt = pat >> 1;
               end
            end
         end
         MODE_FLASH: begin
            pat_nxt = (pat == PAT_ONES) ? '0 : PAT_ONES;
         end
         default: begin
            pat_nxt  = pat;
            bdir_nxt = bdir;
         end
      endcase
   end

   always_comb begin
      o_led   = '0;
      o_led_g = '0;
      o_led_b = '0;
      case (i_color)
         2'b00: o_led   = pat;
         2'b01: o_led_g = pat;
         2'b10: o_led_b = pat;
         default: begin
            o_led   = pat;
            o_led_g = pat;
            o_led_b = pat;
         end
      endcase
   end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer
module tb_led_sequencer;

   typedef struct {
      logic [3:0] pat;
      int         gap;
   } exp_t;

   logic       clock = 1'b0;
   logic       i_reset = 1'b1;
   logic [3:0] i_sw = 4'b0000;
   logic [1:0] i_mode = 2'b00;
   logic [1:0] i_color = 2'b00;
   logic [3:0] o_led;
   logic [3:0] o_led_g;
   logic [3:0] o_led_b;
   logic       o_valid;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   led_sequencer dut (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw),
      .i_mode  (i_mode),
      .i_color (i_color),
      .o_led   (o_led),
      .o_led_g (o_led_g),
      .o_led_b (o_led_b),
      .o_valid (o_valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [3:0] p, input int gap);
      exp_t e;
      e.pat = p;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; consumes one queue entry per observed tick.
   task automatic drain(input int budget);
      int   cycles = 0;
      int   gap = 0;
      exp_t e;
      while (exp_q.size() > 0 && cycles < budget) begin
         @(negedge clock);
         cycles++;
         gap++;
         if (o_valid) begin
            e = exp_q.pop_front();
            check("bank_r", {28'd0, o_led},
                  (i_color == 2'b00 || i_color == 2'b11) ? {28'd0, e.pat} : 32'd0);
            check("bank_g", {28'd0, o_led_g},
                  (i_color == 2'b01 || i_color == 2'b11) ? {28'd0, e.pat} : 32'd0);
            check("bank_b", {28'd0, o_led_b},
                  (i_color == 2'b10 || i_color == 2'b11) ? {28'd0, e.pat} : 32'd0);
            if (e.gap != 0) check("tick_gap", gap, e.gap);
            gap = 0;
         end
      end
      if (exp_q.size() > 0) begin
         check("tick_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic pulse_reset();
      i_reset = 1'b0;
      #1;
      i_reset = 1'b1;
   endtask

   initial begin
      int nvalid;

      // asynchronous reset, observed before any clock edge
      #2 i_reset = 1'b0;
      #1;
      check("rst_led", {28'd0, o_led}, 32'h1);
      check("rst_led_g", {28'd0, o_led_g}, 32'h0);
      check("rst_led_b", {28'd0, o_led_b}, 32'h0);
      check("rst_valid", {31'd0, o_valid}, 32'h0);
      i_sw = 4'b0011;
      @(negedge clock);
      i_reset = 1'b1;

      // rotate toward MSB then LSB, L=4
      push(4'b0010, 4); push(4'b0100, 4); push(4'b1000, 4); push(4'b0001, 4);
      drain(64);
      i_sw = 4'b1011;
      push(4'b1000, 4); push(4'b0100, 4);
      drain(32);

      // ping-pong on green bank, direction switch ignored, L=2
      pulse_reset();
      i_mode = 2'b01; i_sw = 4'b1001; i_color = 2'b01;
      push(4'b0010, 2); push(4'b0100, 2); push(4'b1000, 2); push(4'b0100, 2);
      push(4'b0010, 2); push(4'b0001, 2); push(4'b0010, 2);
      drain(64);

      // one rotate step to 0100, then flash, then back to rotate
      i_mode = 2'b00; i_sw = 4'b0001; i_color = 2'b10;
      push(4'b0100, 2);
      drain(16);
      i_mode = 2'b10;
      push(4'b1111, 2); push(4'b0000, 2); push(4'b1111, 2);
      drain(32);
      i_mode = 2'b00; i_color = 2'b11;
      push(4'b0001, 2);
      drain(16);

      // hold keeps ticking without touching the pattern
      i_mode = 2'b11;
      push(4'b0001, 2); push(4'b0001, 2);
      drain(16);

      // limit shrink below the running count, then disable freezes cnt
      i_sw = 4'b0111;
      repeat (10) @(negedge clock);
      check("lim_cnt10", dut.cnt, 32'd10);
      check("lim_novalid", {31'd0, o_valid}, 32'h0);
      i_sw = 4'b0001;
      @(negedge clock);
      check("lim_tick", {31'd0, o_valid}, 32'h1);
      check("lim_cnt0", dut.cnt, 32'd0);
      i_sw = 4'b0111;
      repeat (3) @(negedge clock);
      i_sw = 4'b0110;
      nvalid = 0;
      repeat (5) begin
         @(negedge clock);
         if (o_valid) nvalid++;
      end
      check("dis_cnt", dut.cnt, 32'd3);
      check("dis_ticks", nvalid, 0);

      // asynchronous reset mid-period
      pulse_reset();
      i_mode = 2'b00; i_sw = 4'b0011; i_color = 2'b00;
      push(4'b0010, 4); push(4'b0100, 4); push(4'b1000, 4);
      drain(64);
      i_sw = 4'b0111;
      repeat (5) @(negedge clock);
      check("mid_cnt5", dut.cnt, 32'd5);
      check("mid_pat", {28'd0, o_led}, 32'h8);
      #2 i_reset = 1'b0;
      #1;
      check("arst_led", {28'd0, o_led}, 32'h1);
      check("arst_cnt", dut.cnt, 32'd0);
      check("arst_valid", {31'd0, o_valid}, 32'h0);
      i_reset = 1'b1;
      i_color = 2'b11;
      #1;
      check("all_r", {28'd0, o_led}, 32'h1);
      check("all_g", {28'd0, o_led_g}, 32'h1);
      check("all_b", {28'd0, o_led_b}, 32'h1);
      @(negedge clock);
      check("resume_cnt", dut.cnt, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Parameters
REQ-001 The block SHALL have parameter N_LEDS, default 4: pattern width, legal range >= 2.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the prescaler counter.
REQ-003 The block SHALL have parameters LIMIT0..LIMIT3, defaults 2, 4, 8, 16: tick periods in clock cycles, each >= 1 and < 2^CNT_W.

Interface
REQ-004 The block SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_sw, input, 4 bits: [0] enable; [2:1] limit select (LIMIT0..LIMIT3); [3] shift direction (0 toward MSB, 1 toward LSB).
REQ-007 The block SHALL have port i_mode, input, 2 bits: 00 rotate, 01 ping-pong, 10 flash, 11 hold.
REQ-008 The block SHALL have port i_color, input, 2 bits: output routing, 00 o_led, 01 o_led_g, 10 o_led_b, 11 all three.
REQ-009 The block SHALL have port o_led, output, N_LEDS bits: red LED bank.
REQ-010 The block SHALL have port o_led_g, output, N_LEDS bits: green LED bank.
REQ-011 The block SHALL have port o_led_b, output, N_LEDS bits: blue LED bank.
REQ-012 The block SHALL have port o_valid, output, 1 bit: one-cycle tick pulse, registered.

Function
REQ-013 Prescaler cnt SHALL be CNT_W bits; L = the LIMIT selected by i_sw[2:1] in the current cycle.
REQ-014 With i_sw[0]=1 and cnt >= L-1, the next edge SHALL load cnt=0 and o_valid=1.
REQ-015 With i_sw[0]=1 and cnt < L-1, the next edge SHALL increment cnt and load o_valid=0.
REQ-016 With i_sw[0]=0, cnt SHALL hold and o_valid SHALL be 0 on the next edge.
REQ-017 A limit-select change below the current cnt SHALL produce a tick on the next edge (>= compare); a period never exceeds the new L.
REQ-018 With L=1, o_valid SHALL remain high continuously while enabled.
REQ-019 Pattern register pat (N_LEDS bits) and bounce direction bdir SHALL update only on the same edge that loads o_valid=1, so the new pattern and the tick become visible together.
REQ-020 Rotate mode SHALL rotate pat by one position toward the MSB (i_sw[3]=0, MSB wraps to bit 0) or toward the LSB (i_sw[3]=1, bit 0 wraps to MSB).
REQ-021 Ping-pong mode SHALL move pat one position in bdir; at the MSB while moving up, or at bit 0 while moving down, the same tick SHALL reverse bdir and move one position (no dwell at the ends); i_sw[3] SHALL be ignored.
REQ-022 In rotate or ping-pong mode, a tick with pat not one-hot SHALL load pat=1 and bdir=up instead of moving.
REQ-023 Flash mode SHALL load all-ones on a tick if pat != all-ones, else all-zeros.
REQ-024 Hold mode SHALL freeze pat and bdir; cnt and o_valid SHALL continue per REQ-014..REQ-016.
REQ-025 A mode change SHALL take effect at the next tick, with no extra latency.
REQ-026 Routing SHALL be combinational from pat and i_color; every unselected bank SHALL drive 0.

Reset
REQ-027 i_reset=0 SHALL immediately, without a clock, force cnt=0, o_valid=0, pat=1 (bit 0 lit) and bdir=up.
REQ-028 Reset release SHALL be synchronised by the integrator; the block SHALL resume counting on the first edge after release.
REQ-029 Reset asserted mid-period SHALL discard the partial count.

Verification
REQ-030 Reset: i_reset=0 with i_color=00 -> o_led=0001, o_led_g=0000, o_led_b=0000, o_valid=0, with no clock edge required.
REQ-031 Rotate: i_sw=0011 (enable, L=4), i_mode=00 -> o_valid high every 4th cycle; o_led 0001, 0010, 0100, 1000, 0001; with i_sw[3]=1 -> 0001, 1000, 0100.
REQ-032 Ping-pong: i_mode=01, L=2 -> successive ticks give 0010, 0100, 1000, 0100, 0010, 0001, 0010.
REQ-033 Flash then rotate: pat=0100, i_mode=10 -> ticks give 1111, 0000, 1111; switching to i_mode=00 -> next tick gives 0001.
REQ-034 Limit change: L=16 with cnt=10, i_sw[2:1] set to 00 (L=2) -> o_valid=1 and cnt=0 on the next edge; with i_sw[0]=0 -> cnt frozen and no ticks.
REQ-035 Async reset mid-operation: pat=1000, cnt=5, i_reset pulsed low between edges -> o_led=0001 and cnt=0 at once; i_color=11 afterwards -> all three banks show 0001.
